// File: rtl/os_skew_feeder.sv
// Operand feeder for one edge of the output-stationary MAC array: a vector FIFO
// followed by a per-row diagonal skew. Optional bubble counter under SKEW_BUBBLE_CNT_EN.

module os_skew_lane #(
    parameter int WORD_SIZE = 16,
    parameter int LAT       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] d,
    output logic [WORD_SIZE-1:0] q
);
    logic [LAT-1:0][WORD_SIZE-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = d;
        for (int k = 1; k < LAT; k++) pipe_d[k] = pipe_q[k-1];
    end

    always_ff @(posedge clk) begin
        if (!rst) pipe_q <= '0;
        else      pipe_q <= pipe_d;
    end

    assign q = pipe_q[LAT-1];
endmodule

module os_skew_feeder #(
    parameter int WORD_SIZE = 16,
    parameter int ROWS      = 4,
    parameter int DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*WORD_SIZE-1:0] in_data,
    input  logic                      in_last,
    output logic [ROWS*WORD_SIZE-1:0] left_out,
    output logic                      busy,
    output logic                      tile_done
`ifdef SKEW_BUBBLE_CNT_EN
    ,
    output logic [15:0]               bubble_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(ROWS) + 1;
    localparam int DW = ROWS * WORD_SIZE;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    state_t          state_q, state_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            full, empty, push, pop, bubble;
    entry_t          head;
    logic [DW-1:0]   lane_in;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    // Held low during reset so nothing is accepted into a FIFO about to be cleared.
    assign in_ready = rst && !full;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pop         = 1'b0;
        bubble      = 1'b0;
        tile_done   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    state_d     = head.last ? S_FLUSH : S_STREAM;
                    flush_cnt_d = '0;
                end
            end
            S_STREAM: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head.last) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = '0;
                    end
                end else begin
                    bubble = 1'b1;
                end
            end
            S_FLUSH: begin
                // Final flush cycle is when the last operand sits on lane ROWS-1.
                if (flush_cnt_q == FW'(ROWS - 1)) begin
                    tile_done = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{last: in_last, data: in_data};
    end

    // Zero when nothing pops: doubles as the flush filler and the stream bubble.
    assign lane_in = pop ? head.data : '0;

    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        os_skew_lane #(
            .WORD_SIZE (WORD_SIZE),
            .LAT       (i + 1)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .d   (lane_in[i*WORD_SIZE +: WORD_SIZE]),
            .q   (left_out[i*WORD_SIZE +: WORD_SIZE])
        );
    end

`ifdef SKEW_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (state_q == S_IDLE && !empty)          bubble_cnt_d = '0;
        else if (bubble && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) bubble_cnt_q <= '0;
        else      bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_os_skew_feeder.sv
// Randomized scoreboard bench for os_skew_feeder: pop times are derived from the
// timing rules at push time and the monitor checks every observable output per cycle.

module tb_os_skew_feeder;
    localparam int W     = 16;
    localparam int ROWS  = 4;
    localparam int DEPTH = 8;
    localparam int DW    = ROWS * W;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic [DW-1:0] left_out;
    logic          busy;
    logic          tile_done;
`ifdef SKEW_BUBBLE_CNT_EN
    logic [15:0]   bubble_cnt;
`endif

    os_skew_feeder #(.WORD_SIZE(W), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .left_out  (left_out),
        .busy      (busy),
        .tile_done (tile_done)
`ifdef SKEW_BUBBLE_CNT_EN
        ,
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            push;
        int            pop;
        logic [DW-1:0] data;
        logic          last;
    } rec_t;

    typedef struct {
        int first;
        int last;
        bit closed;
    } tile_t;

    rec_t          exp_q[$];
    tile_t         tiles[$];
    logic [DW-1:0] hist[int];
    int            next_allowed = 0;
    int            last_pop = 0;
    bit            tile_open = 0;
    bit            chk_en = 0;
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        tiles.delete();
        hist.delete();
        tile_open    = 0;
        next_allowed = 0;
    endtask

    // One cycle of stimulus; an accepted push schedules its pop from the timing rules.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
        rec_t  rc;
        tile_t t;
        rst = r; in_valid = v; in_data = d; in_last = l;
        #1;
        if (v && in_ready) begin
            rc.push = cyc;
            rc.pop  = (cyc + 1 > next_allowed) ? cyc + 1 : next_allowed;
            rc.data = d;
            rc.last = l;
            exp_q.push_back(rc);
            next_allowed = l ? rc.pop + ROWS + 1 : rc.pop + 1;
            last_pop = rc.pop;
            if (!tile_open) begin
                t.first = rc.pop; t.last = 0; t.closed = 0;
                tiles.push_back(t);
                tile_open = 1;
            end
            if (l) begin
                tiles[tiles.size()-1].last   = rc.pop;
                tiles[tiles.size()-1].closed = 1;
                tile_open = 0;
            end
        end
        @(posedge clk);
        if (!r) clear_model();
        #1;
    endtask

    function automatic logic [DW-1:0] vec4(input int a, input int b, input int c, input int e);
        logic [DW-1:0] v;
        v = '0;
        v[0*W +: W] = W'(a); v[1*W +: W] = W'(b);
        v[2*W +: W] = W'(c); v[3*W +: W] = W'(e);
        return v;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    // Monitor: retire pops that just reached lane 0, then check the whole output picture.
    logic [DW-1:0] ev, tmp;
    int            c, occ, hi, ebc;
    logic          ed, eb, found;
    always @(negedge clk) begin
        if (chk_en) begin
            c = cyc;
            while (exp_q.size() > 0 && exp_q[0].pop <= c - 1) begin
                hist[exp_q[0].pop] = exp_q[0].data;
                exp_q.delete(0);
            end
            occ = 0;
            foreach (exp_q[k]) if (exp_q[k].push < c) occ++;
            check("in_ready", 256'(in_ready), 256'(rst && occ < DEPTH));
            ev = '0;
            for (int i = 0; i < ROWS; i++) begin
                if (hist.exists(c - 1 - i)) begin
                    tmp = hist[c - 1 - i];
                    ev[i*W +: W] = tmp[i*W +: W];
                end
            end
            check("left_out", 256'(left_out), 256'(ev));
            ed = 1'b0; eb = 1'b0;
            foreach (tiles[k]) begin
                if (tiles[k].first < c && (!tiles[k].closed || c <= tiles[k].last + ROWS)) eb = 1'b1;
                if (tiles[k].closed && tiles[k].last + ROWS == c) ed = 1'b1;
            end
            check("busy", 256'(busy), 256'(eb));
            check("tile_done", 256'(tile_done), 256'(ed));
`ifdef SKEW_BUBBLE_CNT_EN
            ebc = 0; found = 1'b0;
            for (int k = tiles.size() - 1; k >= 0; k--) begin
                if (!found && tiles[k].first < c) begin
                    found = 1'b1;
                    hi = c - 1;
                    if (tiles[k].closed && tiles[k].last < hi) hi = tiles[k].last;
                    for (int j = tiles[k].first + 1; j <= hi; j++)
                        if (!hist.exists(j)) ebc++;
                end
            end
            check("bubble_cnt", 256'(bubble_cnt), 256'(ebc));
`endif
        end
    end

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk_en = 1;
        idle(2);

        // Skew alignment: three back-to-back vectors, last on the third.
        drive(1'b1, vec4(1, 2, 3, 4), 1'b0, 1'b1);
        drive(1'b1, vec4(5, 6, 7, 8), 1'b0, 1'b1);
        drive(1'b1, vec4(9, 10, 11, 12), 1'b1, 1'b1);
        idle(10);

        // Bubble: two stalled cycles inside a tile.
        drive(1'b1, vec4(1, 1, 1, 1), 1'b0, 1'b1);
        idle(2);
        drive(1'b1, vec4(2, 2, 2, 2), 1'b1, 1'b1);
        idle(10);

        // Single-vector tile.
        drive(1'b1, vec4(7, 7, 7, 7), 1'b1, 1'b1);
        idle(10);

        // Backpressure: single-vector tiles drain slowly, so the FIFO fills and
        // in_valid stays high through the push/pop-at-full cycles.
        for (int k = 0; k < 40; k++)
            drive(1'b1, vec4(k + 1, k + 2, k + 3, k + 4), 1'b1, 1'b1);
        idle(70);

        // Reset two cycles after the last pop, mid-flush.
        drive(1'b1, vec4(3, 3, 3, 3), 1'b1, 1'b1);
        for (int k = 0; k < 10 && cyc < last_pop + 2; k++) idle(1);
        drive(1'b0, '0, 1'b0, 1'b0);
        idle(8);

        // Random traffic with occasional resets.
        for (int k = 0; k < 800; k++)
            drive(($urandom % 3) != 0, DW'({$urandom, $urandom}),
                  ($urandom % 4) == 0, ($urandom % 90) != 0);
        drive(1'b1, vec4(5, 5, 5, 5), 1'b1, 1'b1);
        idle(100);
        check("drain", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/os_skew_feeder.md
# os_skew_feeder

Upstream feeder for one edge of the output-stationary MAC array. Buffers K-step operand vectors (one word per array row) and drives each row's `left_in` with a diagonal skew: row i lags by i cycles, so the operands meet in the wavefront order the PEs expect. After each tile it flushes zeros through the skew and pulses `tile_done`, so the drain logic knows when every row has consumed its last operand.

## Interface
- `WORD_SIZE`, 16, operand width; matches the MAC word.
- `ROWS`, 4, number of array rows (lanes); legal values 2..16.
- `DEPTH`, 8, FIFO depth in vectors; power of two, at least 2.
- `clk` input 1: the single clock, rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `in_valid` input 1: upstream vector valid.
- `in_ready` output 1: FIFO can accept a vector.
- `in_data` input ROWS*WORD_SIZE: lane i at bits [i*WORD_SIZE +: WORD_SIZE].
- `in_last` input 1: marks the final K-step vector of a tile.
- `left_out` output ROWS*WORD_SIZE: lane i drives row i `left_in`.
- `busy` output 1: state is STREAM or FLUSH.
- `tile_done` output 1: one-cycle pulse when the last operand reaches lane ROWS-1.

## Operation
- FIFO:
  - DEPTH entries of {in_data, in_last}.
  - Push on `in_valid && in_ready`.
  - `in_ready = !full`, driven from the registered count.
  - Push and pop in the same cycle are legal, count unchanged.
  - A vector pushed in cycle t is poppable at t+1 at the earliest.
- Skew: lane i has i+1 registers (lane 0: one register). All lanes shift every cycle, in every state. The input to the lanes is the popped vector, or all-zero when nothing is popped.
- States:
  - IDLE: no pop.
    - FIFO non-empty: pop this cycle and go to STREAM.
    - If the popped entry has last=1, go to FLUSH instead.
  - STREAM: pop every cycle the FIFO is non-empty.
    - FIFO empty: inject a zero bubble across all lanes, which keeps alignment; a zero product adds nothing.
    - Popped entry has last=1: go to FLUSH.
  - FLUSH: no pops; pushes are still accepted.
    - Counter runs ROWS cycles, then returns to IDLE.
    - `tile_done` is high in the final FLUSH cycle.
- Arithmetic: none. Data passes unmodified; count width is clog2(DEPTH)+1; FLUSH counter width is clog2(ROWS)+1.
- Reset (`rst`=0 at a clock edge, including mid-tile):
  - FIFO emptied; all skew registers and `left_out` cleared to 0.
  - State to IDLE; `busy`=0, `tile_done`=0.
  - `in_ready`=0 while reset is asserted, 1 in the first cycle after release.
  - In-flight tiles are discarded; no `tile_done` is produced for them.

## Timing
- Vector popped in cycle T appears on lane i of `left_out` in cycle T+1+i.
- Last vector popped at T:
  - FLUSH occupies T+1..T+ROWS.
  - `tile_done`=1 exactly in cycle T+ROWS, coincident with lane ROWS-1 showing it.
  - IDLE from T+ROWS+1; the next tile's first pop is at T+ROWS+1 at the earliest.
- Back-to-back full FIFO: one pop per cycle, no bubbles. `in_ready` reasserts the cycle after the first pop from full.
- Single-vector tile (first entry has last=1): IDLE to FLUSH directly; `tile_done` at T+ROWS.

## Configuration
- `SKEW_BUBBLE_CNT_EN` defined:
  - Adds output `bubble_cnt` [15:0], counting zero bubbles injected in STREAM, saturating at 16'hFFFF.
  - Cleared to 0 on reset and on every IDLE-to-STREAM/FLUSH transition; holds its value after `tile_done` until the next tile starts.
- Not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Skew alignment (ROWS=4):
  - Stimulus: push vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12} with last on the third; first pop at cycle 0.
  - Required: lane0 shows 1,5,9 at cycles 1..3; lane3 shows 4,8,12 at cycles 4..6; `tile_done` at cycle 6; `busy` low at cycle 7.
- Backpressure:
  - Stimulus: hold `in_valid`=1 while the FIFO fills to DEPTH=8.
  - Required: `in_ready`=0 once 8 entries are held; no data lost or duplicated; `in_ready`=1 the cycle after the first pop.
- Bubble:
  - Stimulus: push {1,1,1,1}; stall 2 cycles; push {2,2,2,2} with last.
  - Required: every lane shows 1,0,0,2 in order, skewed by its index; `bubble_cnt`=2 with the macro defined.
- Single-vector tile:
  - Stimulus: push {7,7,7,7} with last.
  - Required: IDLE goes directly to FLUSH; `tile_done` 4 cycles after the pop; lane3 shows 7 in the same cycle.
- Reset mid-FLUSH:
  - Stimulus: drive `rst`=0 for one cycle two cycles after the last pop.
  - Required: `left_out`=0, `busy`=0, no `tile_done`, FIFO empty, `in_ready`=1 the cycle after release.
- Simultaneous push and pop at full:
  - Stimulus: full FIFO, `in_valid`=1 on the cycle `in_ready` reasserts.
  - Required: count stays at 8; output order is preserved.
